// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial two's-complement subtractor, D = A - B, LSB first.
//                One full-subtractor cell plus a registered borrow processes
//                one bit per clock. Operands are latched on an accepted start,
//                the operation runs for WIDTH cycles, and the registered
//                result is presented with borrow, overflow and zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             V,
  output logic             Z
);

  // Counter only needs to reach WIDTH-1; $clog2(WIDTH) >= 1 for WIDTH >= 2.
  localparam int            CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;        // minuend shift register, consumed LSB first
  logic [WIDTH-1:0] sb;        // subtrahend shift register, consumed LSB first
  logic [WIDTH-1:0] res;       // result shift register, filled from the MSB end
  logic             br;        // borrow carried between bit positions
  logic [CNT_W-1:0] cnt;       // index of the bit processed on the next edge
  logic             sign_a;    // operand signs captured at accept for overflow
  logic             sign_b;

  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current bit pair and the running borrow.
  assign diff_bit    = sa[0] ^ sb[0] ^ br;
  assign borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  // After WIDTH shifts bit 0 has travelled all the way down to res[0].
  assign res_next    = {diff_bit, res[WIDTH-1:1]};

  // Control FSM, datapath shifting and registered result/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bo     <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE is a single-cycle state; start here gives back-to-back ops.
          done <= 1'b0;
          if (start) begin
            sa     <= A;
            sb     <= B;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            sign_a <= A[WIDTH-1];
            sign_b <= B[WIDTH-1];
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end

        S_RUN: begin
          // start is deliberately ignored here; the in-flight op is protected.
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= borrow_next;
          res <= res_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Results and flags only ever change on this edge.
            busy  <= 1'b0;
            done  <= 1'b1;
            D     <= res_next;
            Bo    <= borrow_next;
            Z     <= (res_next == '0);
            V     <= (sign_a ^ sign_b) & (res_next[WIDTH-1] ^ sign_a);
            state <= S_DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
